// File: rtl/uart_pkg.sv
// Shared UART constants: default byte width, default receive-buffer depth,
// and the pointer width derivation used by the receive FIFO.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_DEPTH      = 16;

    // Address bits plus one wrap bit so that full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer between the UART receiver and the APB slave:
// first-word-fall-through FIFO with fill level, sticky overrun and threshold irq.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = UART_DEPTH,
    parameter int IRQ_LEVEL  = 1
) (
    input  logic                         pclk,
    input  logic                         prstn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overrun,
    input  logic                         overrun_clr,
    output logic                         irq
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] IRQ_LVL = PW'(IRQ_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overrun_q, overrun_d;

    logic full, empty;
    logic do_wr, do_rd, ovr_set;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr_q[AW-1:0]];
    assign level     = wr_ptr_q - rd_ptr_q;
    assign overrun   = overrun_q;
    assign irq       = (level >= IRQ_LVL) || overrun_q;

    // Flush suppresses both transfers; a byte offered to a full FIFO is still
    // lost during a flush, so the overrun set term ignores flush.
    assign do_wr   = in_valid && !full && !flush;
    assign do_rd   = !empty && out_ready && !flush;
    assign ovr_set = in_valid && full;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (ovr_set)          overrun_d = 1'b1;
        else if (overrun_clr) overrun_d = 1'b0;
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage carries no reset; contents are only visible once a pointer covers them.
    always_ff @(posedge pclk) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= in_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue of expected bytes is pushed on
// accepted writes and popped on reads; flags are predicted alongside.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int IRQL  = 1;

    logic          pclk = 1'b0;
    logic          prstn;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic          flush, overrun, overrun_clr, irq;
    logic [4:0]    level;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [DW-1:0] sb [$];
    bit            m_ovr;

    always #5 pclk = ~pclk;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IRQ_LEVEL(IRQL)) dut (
        .pclk(pclk), .prstn(prstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .level(level), .overrun(overrun),
        .overrun_clr(overrun_clr), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"},    32'(level), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_out_valid"},32'(out_valid), 0);
        chk({tag, "_overrun"},  32'(overrun), 0);
        chk({tag, "_irq"},      32'(irq), 0);
    endtask

    // One clock: drive inputs, predict, check data on reads, then check flags after the edge.
    task automatic cycle(input logic vin, input logic [DW-1:0] din, input logic rdy,
                         input logic fl, input logic oclr);
        bit m_full, m_empty, set;
        logic [DW-1:0] exp_b;
        in_valid = vin; in_data = din; out_ready = rdy; flush = fl; overrun_clr = oclr;
        m_full  = (sb.size() == DEPTH);
        m_empty = (sb.size() == 0);
        set     = vin && m_full;
        if (fl) begin
            sb.delete();
        end else begin
            if (rdy && !m_empty) begin
                exp_b = sb.pop_front();
                chk("rd_data", 32'(out_data), 32'(exp_b));
            end
            if (vin && !m_full) sb.push_back(din);
        end
        if (set)       m_ovr = 1'b1;
        else if (oclr) m_ovr = 1'b0;
        @(posedge pclk); #1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
        chk("level",     32'(level),     32'(sb.size()));
        chk("in_ready",  32'(in_ready),  32'(sb.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        chk("overrun",   32'(overrun),   32'(m_ovr));
        chk("irq",       32'(irq),       32'((sb.size() >= IRQL) || m_ovr));
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        prstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; overrun_clr = 1'b0; m_ovr = 1'b0;
        #3;
        chk_reset_vals("rst");
        repeat (2) @(posedge pclk);
        #1 prstn = 1'b1;

        // Three back-to-back writes with the consumer stalled
        cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        chk("fwft_data", 32'(out_data), 32'h41);
        cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        chk("lvl3", 32'(level), 3);
        drain();

        // Fill to the brim, then offer one more byte
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", 32'(in_ready), 0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        chk("full_drop_ovr", 32'(overrun), 1);
        drain();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clr", 32'(overrun), 0);

        // Continuous streaming across pointer wrap
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
            chk("stream_lvl_le1", 32'(level <= 5'd1), 1);
        end
        drain();

        // Full with simultaneous read and an incoming byte
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("full_rw_lvl", 32'(level), 15);
        chk("full_rw_ovr", 32'(overrun), 1);
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("after_full_wr", 32'(level), 16);
        drain();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Flush beats a concurrent write and read
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        chk("flush_lvl", 32'(level), 0);
        chk("flush_ovalid", 32'(out_valid), 0);
        chk("flush_ovr", 32'(overrun), 0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        drain();

        // Overrun set wins over a coincident clear
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        chk("set_beats_clr", 32'(overrun), 1);

        // Down to seven entries, then asynchronous reset in the middle of a write
        for (int i = 0; i < DEPTH - 7; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_lvl", 32'(level), 7);
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        #3 prstn = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        in_valid = 1'b0; out_ready = 1'b0;
        sb.delete(); m_ovr = 1'b0;
        @(posedge pclk); #1;
        chk_reset_vals("rst_hold");
        prstn = 1'b1;
        cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
